// File: rtl/rc4_ksa_engine.sv
// RC4 key-scheduling engine over a single-port S-box RAM with 1-cycle read latency.
// Optional in-line S-box init (S[i]=i) before the schedule when RC4_KSA_INIT_EN is defined.
module rc4_ksa_engine #(
  parameter int N_BITS    = 8,
  parameter int KEY_BYTES = 3
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           start,
  input  logic [KEY_BYTES*N_BITS-1:0]    key,
  input  logic [$clog2(KEY_BYTES+1)-1:0] key_len,
  input  logic [N_BITS-1:0]              mem_rdata,
  output logic [N_BITS-1:0]              mem_addr,
  output logic [N_BITS-1:0]              mem_wdata,
  output logic                           mem_we,
  output logic                           busy,
  output logic                           done
);
  localparam int KL_W = $clog2(KEY_BYTES + 1);
  localparam int KI_W = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;
  localparam logic [KL_W-1:0]   LEN_MAX = KL_W'(KEY_BYTES);
  localparam logic [N_BITS-1:0] I_LAST  = '1;

  typedef enum logic [3:0] {
    IDLE, INIT, RD_I, CAP_I, CALC_J, RD_J, CAP_J, WR_J, WR_I, DONE
  } state_t;

  state_t                      state, state_nxt;
  logic [KEY_BYTES*N_BITS-1:0] key_q;
  logic [KL_W-1:0]             len_q, len_clamped;
  logic [KI_W-1:0]             kidx;
  logic [N_BITS-1:0]           i, j, si, sj, key_byte;
  logic                        kidx_last;

  assign len_clamped = (key_len == '0 || key_len > LEN_MAX) ? LEN_MAX : key_len;
  assign kidx_last   = (KL_W'(kidx) == len_q - KL_W'(1));

  // Byte 0 sits in the most significant slot of the key bus.
  always_comb begin
    key_byte = '0;
    for (int b = 0; b < KEY_BYTES; b++)
      if (KI_W'(b) == kidx) key_byte = key_q[(KEY_BYTES-1-b)*N_BITS +: N_BITS];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      i     <= '0;
      j     <= '0;
      kidx  <= '0;
      si    <= '0;
      sj    <= '0;
      key_q <= '0;
      len_q <= LEN_MAX;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (start) begin
          key_q <= key;
          len_q <= len_clamped;
          i     <= '0;
          j     <= '0;
          kidx  <= '0;
        end
        INIT:   i  <= i + N_BITS'(1);
        CAP_I:  si <= mem_rdata;
        CALC_J: j  <= j + si + key_byte;
        CAP_J:  sj <= mem_rdata;
        WR_I: begin
          i    <= i + N_BITS'(1);
          kidx <= kidx_last ? '0 : kidx + KI_W'(1);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) begin
`ifdef RC4_KSA_INIT_EN
        state_nxt = INIT;
`else
        state_nxt = RD_I;
`endif
      end
      INIT:    if (i == I_LAST) state_nxt = RD_I;
      RD_I:    state_nxt = CAP_I;
      CAP_I:   state_nxt = CALC_J;
      CALC_J:  state_nxt = RD_J;
      RD_J:    state_nxt = CAP_J;
      CAP_J:   state_nxt = WR_J;
      WR_J:    state_nxt = WR_I;
      WR_I:    state_nxt = (i == I_LAST) ? DONE : RD_I;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Writes are masked while reset is high so an abandoned run leaves RAM untouched that cycle.
  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_we    = 1'b0;
    busy      = (state != IDLE);
    done      = 1'b0;
    case (state)
      INIT: begin
        mem_addr  = i;
        mem_wdata = i;
        mem_we    = !reset;
      end
      RD_I, CAP_I, CALC_J: mem_addr = i;
      RD_J, CAP_J:         mem_addr = j;
      WR_J: begin
        mem_addr  = j;
        mem_wdata = si;
        mem_we    = !reset;
      end
      WR_I: begin
        mem_addr  = i;
        mem_wdata = sj;
        mem_we    = !reset;
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_rc4_ksa_engine.sv
// Bench for rc4_ksa_engine: 8-bit and 3-bit instances, each on its own behavioural RAM,
// results compared against a plain-arithmetic RC4 KSA model.
module tb_rc4_ksa_engine;
`ifdef RC4_KSA_INIT_EN
  localparam int LAT_MUL = 8;
  localparam int PRE_FF  = 1;
`else
  localparam int LAT_MUL = 7;
  localparam int PRE_FF  = 0;
`endif

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic        start8 = 1'b0, start3 = 1'b0;
  logic [23:0] key8 = '0;
  logic [8:0]  key3 = '0;
  logic [1:0]  len8 = '0, len3 = '0;
  logic [7:0]  rdata8, addr8, wdata8;
  logic [2:0]  rdata3, addr3, wdata3;
  logic        we8, busy8, done8, we3, busy3, done3;

  logic [7:0]  ram8 [256];
  logic [2:0]  ram3 [8];
  logic [7:0]  pre8 [256];
  logic [2:0]  pre3 [8];
  logic        load = 1'b0;

  int ms[];
  int checks = 0;
  int failures = 0;

  rc4_ksa_engine #(.N_BITS(8), .KEY_BYTES(3)) dut8 (
    .clock(clock), .reset(reset), .start(start8), .key(key8), .key_len(len8),
    .mem_rdata(rdata8), .mem_addr(addr8), .mem_wdata(wdata8), .mem_we(we8),
    .busy(busy8), .done(done8)
  );

  rc4_ksa_engine #(.N_BITS(3), .KEY_BYTES(3)) dut3 (
    .clock(clock), .reset(reset), .start(start3), .key(key3), .key_len(len3),
    .mem_rdata(rdata3), .mem_addr(addr3), .mem_wdata(wdata3), .mem_we(we3),
    .busy(busy3), .done(done3)
  );

  always @(posedge clock) begin
    if (load) begin
      for (int k = 0; k < 256; k++) ram8[k] <= pre8[k];
      for (int k = 0; k < 8; k++)   ram3[k] <= pre3[k];
    end else begin
      if (we8) ram8[addr8] <= wdata8;
      if (we3) ram3[addr3] <= wdata3;
    end
    rdata8 <= ram8[addr8];
    rdata3 <= ram3[addr3];
  end

  task automatic preload();
    for (int k = 0; k < 256; k++) pre8[k] = (PRE_FF != 0) ? 8'hFF : 8'(k);
    for (int k = 0; k < 8; k++)   pre3[k] = (PRE_FF != 0) ? 3'h7 : 3'(k);
    load = 1'b1;
    @(posedge clock); #1;
    load = 1'b0;
  endtask

  task automatic ms_reset(input int nb);
    ms = new[1 << nb];
    for (int k = 0; k < (1 << nb); k++) ms[k] = k;
  endtask

  // Software RC4 KSA; continues from the current ms unless the engine does its own init.
  task automatic ksa_model(input int nb, input int key, input int len);
    int d, j, l, t, kb;
    d = 1 << nb;
    j = 0;
    l = (len == 0 || len > 3) ? 3 : len;
`ifdef RC4_KSA_INIT_EN
    ms_reset(nb);
`endif
    for (int i = 0; i < d; i++) begin
      kb = (key >> ((2 - (i % l)) * nb)) & (d - 1);
      j = (j + ms[i] + kb) % d;
      t = ms[i]; ms[i] = ms[j]; ms[j] = t;
    end
  endtask

  task automatic check_ram(input int sel, input string name);
    int bad, first, d, v;
    bad = 0; first = -1; d = sel ? 8 : 256;
    for (int k = 0; k < d; k++) begin
      v = sel ? int'(ram3[k]) : int'(ram8[k]);
      if (v != ms[k]) begin
        bad++;
        if (first < 0) first = k;
      end
    end
    checks++;
    if (bad != 0) begin
      failures++;
      v = sel ? int'(ram3[first]) : int'(ram8[first]);
      $display("FAIL %s: %0d entries differ, S[%0d]=%0d expected %0d", name, bad, first, v, ms[first]);
    end
  endtask

  // Starts a run on an idle engine, optionally re-pulses start (with new key) at cycle poke,
  // checks busy, done latency and pulse width, and returns on the first idle cycle.
  task automatic run(input int sel, input int key, input int len, input int poke, input string name);
    int cyc, lat, exp_lat;
    exp_lat = LAT_MUL * (sel ? 8 : 256) + 1;
    if (sel) begin start3 = 1'b1; key3 = 9'(key); len3 = 2'(len); end
    else     begin start8 = 1'b1; key8 = 24'(key); len8 = 2'(len); end
    @(posedge clock); #1;
    start3 = 1'b0; start8 = 1'b0;
    checks++;
    if ((sel ? busy3 : busy8) !== 1'b1) begin
      failures++;
      $display("FAIL %s busy_accept: got %b want 1", name, sel ? busy3 : busy8);
    end
    cyc = 1; lat = -1;
    while (cyc < 4000) begin
      if ((sel ? done3 : done8) === 1'b1) begin lat = cyc; break; end
      if (sel) start3 = (cyc == poke); else start8 = (cyc == poke);
      if (cyc == poke) begin
        key8 = 24'($urandom); key3 = 9'($urandom);
        len8 = 2'($urandom);  len3 = 2'($urandom);
      end
      @(posedge clock); #1;
      cyc++;
    end
    start3 = 1'b0; start8 = 1'b0;
    checks++;
    if (lat != exp_lat) begin
      failures++;
      $display("FAIL %s latency: got %0d want %0d", name, lat, exp_lat);
    end
    checks++;
    if ((sel ? busy3 : busy8) !== 1'b1) begin
      failures++;
      $display("FAIL %s busy_at_done: got %b want 1", name, sel ? busy3 : busy8);
    end
    @(posedge clock); #1;
    checks++;
    if ((sel ? done3 : done8) !== 1'b0 || (sel ? busy3 : busy8) !== 1'b0) begin
      failures++;
      $display("FAIL %s done_pulse: done=%b busy=%b want 0/0", name,
               sel ? done3 : done8, sel ? busy3 : busy8);
    end
  endtask

  task automatic test_reset();
    checks++; if (busy8 !== 1'b0) begin failures++; $display("FAIL reset_busy8: got %b want 0", busy8); end
    checks++; if (done8 !== 1'b0) begin failures++; $display("FAIL reset_done8: got %b want 0", done8); end
    checks++; if (we8 !== 1'b0) begin failures++; $display("FAIL reset_we8: got %b want 0", we8); end
    checks++; if (addr8 !== 8'h00) begin failures++; $display("FAIL reset_addr8: got %h want 00", addr8); end
    checks++; if (wdata8 !== 8'h00) begin failures++; $display("FAIL reset_wdata8: got %h want 00", wdata8); end
    checks++; if (busy3 !== 1'b0) begin failures++; $display("FAIL reset_busy3: got %b want 0", busy3); end
    checks++; if (we3 !== 1'b0) begin failures++; $display("FAIL reset_we3: got %b want 0", we3); end
  endtask

  task automatic test_spec_key();
    preload(); ms_reset(8); ksa_model(8, 24'h000249, 3);
    run(0, 24'h000249, 3, -1, "spec_key");
    check_ram(0, "spec_key_ram");
  endtask

  task automatic test_small_key();
    int k;
    k = (5 << 6) | int'($urandom_range(0, 63));
    preload(); ms_reset(3); ksa_model(3, k, 1);
    run(1, k, 1, -1, "small_key");
    check_ram(1, "small_key_ram");
  endtask

  task automatic test_random();
    int k, l;
    for (int n = 0; n < 4; n++) begin
      k = int'($urandom_range(0, 24'hFFFFFF)); l = int'($urandom_range(0, 3));
      preload(); ms_reset(8); ksa_model(8, k, l);
      run(0, k, l, -1, "random8");
      check_ram(0, "random8_ram");
      k = int'($urandom_range(0, 511)); l = int'($urandom_range(0, 3));
      preload(); ms_reset(3); ksa_model(3, k, l);
      run(1, k, l, -1, "random3");
      check_ram(1, "random3_ram");
    end
  endtask

  task automatic test_restart_ignored();
    int k;
    k = int'($urandom_range(0, 24'hFFFFFF));
    preload(); ms_reset(8); ksa_model(8, k, 2);
    run(0, k, 2, 100, "restart");
    check_ram(0, "restart_ram");
  endtask

  task automatic test_key_len_zero();
    int k, bad;
    int saved[];
    k = int'($urandom_range(0, 24'hFFFFFF));
    preload(); ms_reset(8); ksa_model(8, k, 0);
    run(0, k, 0, -1, "len0");
    check_ram(0, "len0_ram");
    saved = new[256];
    for (int n = 0; n < 256; n++) saved[n] = int'(ram8[n]);
    preload();
    run(0, k, 3, -1, "len3");
    bad = 0;
    for (int n = 0; n < 256; n++) if (int'(ram8[n]) != saved[n]) bad++;
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL len0_vs_len3: %0d entries differ, want 0", bad);
    end
  endtask

  task automatic test_back_to_back();
    int k1, k2;
    k1 = int'($urandom_range(0, 24'hFFFFFF)); k2 = int'($urandom_range(0, 24'hFFFFFF));
    preload(); ms_reset(8); ksa_model(8, k1, 3);
    run(0, k1, 3, -1, "b2b_first");
    check_ram(0, "b2b_first_ram");
    ksa_model(8, k2, 3);
    run(0, k2, 3, -1, "b2b_second");
    check_ram(0, "b2b_second_ram");
  endtask

  task automatic abort_run(input int sel, input int cyc_at, input string name);
    int bad, d;
    int snap[];
    d = sel ? 8 : 256;
    if (sel) begin start3 = 1'b1; key3 = 9'($urandom); len3 = 2'($urandom); end
    else     begin start8 = 1'b1; key8 = 24'($urandom); len8 = 2'($urandom); end
    @(posedge clock); #1;
    start3 = 1'b0; start8 = 1'b0;
    for (int c = 1; c < cyc_at; c++) begin @(posedge clock); #1; end
    reset = 1'b1;
    snap = new[d];
    for (int n = 0; n < d; n++) snap[n] = sel ? int'(ram3[n]) : int'(ram8[n]);
    @(posedge clock); #1;
    reset = 1'b0;
    checks++;
    if ((sel ? busy3 : busy8) !== 1'b0 || (sel ? done3 : done8) !== 1'b0) begin
      failures++;
      $display("FAIL %s busy_done: busy=%b done=%b want 0/0", name,
               sel ? busy3 : busy8, sel ? done3 : done8);
    end
    checks++;
    if ((sel ? we3 : we8) !== 1'b0 || (sel ? int'(addr3) : int'(addr8)) != 0) begin
      failures++;
      $display("FAIL %s idle_outputs: we=%b addr=%0d want 0/0", name,
               sel ? we3 : we8, sel ? int'(addr3) : int'(addr8));
    end
    bad = 0;
    for (int n = 0; n < d; n++) if ((sel ? int'(ram3[n]) : int'(ram8[n])) != snap[n]) bad++;
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL %s no_write: %0d entries changed in reset cycle, want 0", name, bad);
    end
  endtask

  task automatic test_reset_midrun();
    int k;
    preload();
    abort_run(0, 500, "abort8");
    k = int'($urandom_range(0, 24'hFFFFFF));
    preload(); ms_reset(8); ksa_model(8, k, 3);
    run(0, k, 3, -1, "after_abort8");
    check_ram(0, "after_abort8_ram");
    preload();
    abort_run(1, 6, "abort3_write");
    k = int'($urandom_range(0, 511));
    preload(); ms_reset(3); ksa_model(3, k, 2);
    run(1, k, 2, -1, "after_abort3");
    check_ram(1, "after_abort3_ram");
  endtask

  initial begin
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    test_reset();
    reset = 1'b0;
    @(posedge clock); #1;
    test_spec_key();
    test_small_key();
    test_random();
    test_restart_ignored();
    test_key_len_zero();
    test_back_to_back();
    test_reset_midrun();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
